// File: rtl/sd_serializer.sv
// sd_serializer: srdy/drdy width-down converter. Takes one wide word of
// `ratio` beats and emits 1..ratio narrow beats, flagging the last with
// p_last. A new word is accepted in the cycle the last beat is taken.
module sd_serializer #(
    parameter int pwidth = 8,
    parameter int ratio  = 4,
    parameter int lenw   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c_srdy,
    output logic                      c_drdy,
    input  logic [ratio*pwidth-1:0]   c_data,
    input  logic [lenw-1:0]           c_len,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [pwidth-1:0]         p_data,
    output logic                      p_last
);

    // Shift register keeps at least one beat of storage so ratio=1 stays legal.
    localparam int SRW = (ratio > 1) ? (ratio - 1) * pwidth : pwidth;
    localparam logic [lenw-1:0] MAXLEN = lenw'(ratio - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [pwidth-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [SRW-1:0]    sr_q, sr_d;
    logic [lenw-1:0]   len_q, len_d;
    logic [lenw-1:0]   cnt_q, cnt_d;

    logic [SRW-1:0]    c_upper;
    logic [lenw-1:0]   c_len_clamped;
    logic [lenw-1:0]   cnt_inc;
    logic              accept;
    logic              take;

    generate
        if (ratio > 1) begin : g_upper
            assign c_upper = c_data[ratio*pwidth-1:pwidth];
        end else begin : g_no_upper
            assign c_upper = '0;
        end

        // Clamp only exists when c_len can encode more beats than a word holds.
        if ((2 ** lenw) > ratio) begin : g_clamp
            assign c_len_clamped = (c_len > MAXLEN) ? MAXLEN : c_len;
        end else begin : g_no_clamp
            assign c_len_clamped = c_len;
        end
    endgenerate

    assign p_srdy  = (state_q == S_SEND);
    assign p_data  = data_q;
    assign p_last  = last_q;
    assign c_drdy  = reset && (!p_srdy || (p_drdy && p_last));
    assign accept  = c_srdy && c_drdy;
    assign take    = p_srdy && p_drdy;
    assign cnt_inc = cnt_q + lenw'(1);

    // Next-state: advance through stored beats, load a new word, or go idle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        sr_d    = sr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (take && !last_q) begin
            data_d = sr_q[pwidth-1:0];
            sr_d   = sr_q >> pwidth;
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == len_q);
        end else if (accept) begin
            state_d = S_SEND;
            data_d  = c_data[pwidth-1:0];
            sr_d    = c_upper;
            len_d   = c_len_clamped;
            cnt_d   = '0;
            last_d  = (c_len_clamped == '0);
        end else if (take) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            sr_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sd_serializer.sv
// Directed self-checking bench for sd_serializer (ratio=4 and ratio=3 instances).
module tb_sd_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        c_srdy = 1'b0;
    logic        c_drdy;
    logic [31:0] c_data = '0;
    logic [1:0]  c_len = '0;
    logic        p_srdy;
    logic        p_drdy = 1'b0;
    logic [7:0]  p_data;
    logic        p_last;

    logic        c3_srdy = 1'b0;
    logic        c3_drdy;
    logic [23:0] c3_data = '0;
    logic [1:0]  c3_len = '0;
    logic        p3_srdy;
    logic        p3_drdy = 1'b1;
    logic [7:0]  p3_data;
    logic        p3_last;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_serializer #(.pwidth(8), .ratio(4), .lenw(2)) dut (
        .clk(clk), .reset(rst_n),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_len(c_len),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_last(p_last)
    );

    sd_serializer #(.pwidth(8), .ratio(3), .lenw(2)) dut3 (
        .clk(clk), .reset(rst_n),
        .c_srdy(c3_srdy), .c_drdy(c3_drdy), .c_data(c3_data), .c_len(c3_len),
        .p_srdy(p3_srdy), .p_drdy(p3_drdy), .p_data(p3_data), .p_last(p3_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic srdy, input logic [7:0] data, input logic last);
        chk({tag, ".p_srdy"}, 32'(p_srdy), 32'(srdy));
        chk({tag, ".p_data"}, 32'(p_data), 32'(data));
        chk({tag, ".p_last"}, 32'(p_last), 32'(last));
    endtask

    task automatic chk_out3(input string tag, input logic srdy, input logic [7:0] data, input logic last);
        chk({tag, ".p3_srdy"}, 32'(p3_srdy), 32'(srdy));
        chk({tag, ".p3_data"}, 32'(p3_data), 32'(data));
        chk({tag, ".p3_last"}, 32'(p3_last), 32'(last));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bp_data [7];
        logic       bp_last [7];
        logic       bp_drdy [7];
        logic       bp_cdrdy[7];
        bp_data  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};
        bp_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bp_drdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp_cdrdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset and idle
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst", 1'b0, 8'h00, 1'b0);
        chk("rst.c_drdy", 32'(c_drdy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle.c_drdy", 32'(c_drdy), 32'd1);
        tick();
        chk_out("idle", 1'b0, 8'h00, 1'b0);
        chk("idle3.c_drdy", 32'(c3_drdy), 32'd1);

        // Single 4-beat word, p_drdy held high
        c_srdy = 1'b1; c_data = 32'h44332211; c_len = 2'd3; p_drdy = 1'b1;
        tick();
        c_srdy = 1'b0;
        chk_out("w4.b0", 1'b1, 8'h11, 1'b0);
        tick(); chk_out("w4.b1", 1'b1, 8'h22, 1'b0);
        tick(); chk_out("w4.b2", 1'b1, 8'h33, 1'b0);
        tick(); chk_out("w4.b3", 1'b1, 8'h44, 1'b1);
        tick(); chk_out("w4.end", 1'b0, 8'h44, 1'b0);

        // Back-to-back words, c_srdy held high
        c_srdy = 1'b1; c_data = 32'h44332211; c_len = 2'd3;
        tick();
        c_data = 32'hDDCCBBAA; c_len = 2'd1;
        chk_out("b2b.b0", 1'b1, 8'h11, 1'b0);
        chk("b2b.b0.c_drdy", 32'(c_drdy), 32'd0);
        tick(); chk_out("b2b.b1", 1'b1, 8'h22, 1'b0);
        tick(); chk_out("b2b.b2", 1'b1, 8'h33, 1'b0);
        tick(); chk_out("b2b.b3", 1'b1, 8'h44, 1'b1);
        chk("b2b.b3.c_drdy", 32'(c_drdy), 32'd1);
        tick();
        c_srdy = 1'b0;
        chk_out("b2b.b4", 1'b1, 8'hAA, 1'b0);
        tick(); chk_out("b2b.b5", 1'b1, 8'hBB, 1'b1);
        tick(); chk("b2b.end.p_srdy", 32'(p_srdy), 32'd0);

        // Backpressure pattern on a 4-beat word
        c_srdy = 1'b1; c_data = 32'h44332211; c_len = 2'd3; p_drdy = 1'b1;
        tick();
        c_srdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk_out($sformatf("bp%0d", k), 1'b1, bp_data[k], bp_last[k]);
            p_drdy = bp_drdy[k];
            #1;
            chk($sformatf("bp%0d.c_drdy", k), 32'(c_drdy), 32'(bp_cdrdy[k]));
            tick();
        end
        chk("bp.end.p_srdy", 32'(p_srdy), 32'd0);

        // c_len=0 single beat on ratio 4; clamped length on ratio 3
        p_drdy = 1'b1;
        c_srdy = 1'b1; c_data = 32'h44332211; c_len = 2'd0;
        c3_srdy = 1'b1; c3_data = 24'h332211; c3_len = 2'd3;
        tick();
        c_srdy = 1'b0;
        c3_srdy = 1'b0;
        chk_out("len0", 1'b1, 8'h11, 1'b1);
        chk_out3("clamp.b0", 1'b1, 8'h11, 1'b0);
        tick();
        chk("len0.end.p_srdy", 32'(p_srdy), 32'd0);
        chk_out3("clamp.b1", 1'b1, 8'h22, 1'b0);
        tick(); chk_out3("clamp.b2", 1'b1, 8'h33, 1'b1);
        tick(); chk("clamp.end.p3_srdy", 32'(p3_srdy), 32'd0);

        // Reset pulse after the second beat of a 4-beat word
        c_srdy = 1'b1; c_data = 32'h44332211; c_len = 2'd3;
        tick();
        c_srdy = 1'b0;
        chk_out("mid.b0", 1'b1, 8'h11, 1'b0);
        tick();
        chk_out("mid.b1", 1'b1, 8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("mid.rst", 1'b0, 8'h00, 1'b0);
        chk("mid.rst.c_drdy", 32'(c_drdy), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid.rel.c_drdy", 32'(c_drdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mid.after%0d.p_srdy", k), 32'(p_srdy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
